// File: rtl/result_pkg.sv
// Shared types for the result drain path: tag layout, FSM states, round-robin pick.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package result_pkg;

    localparam int RES_D_WIDTH      = 64;
    localparam int RES_PE_NUM_WIDTH = 1;
    localparam int RES_ADDR_WIDTH   = 5;
    localparam int PE_NUM           = 1 << RES_PE_NUM_WIDTH;

    // Source coordinates that travel with every drained word.
    typedef struct packed {
        logic [RES_PE_NUM_WIDTH-1:0] pe;
        logic [RES_ADDR_WIDTH-1:0]   addr;
    } result_tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rc_state_t;

    // First requester at or after ptr, wrapping. Scanning downwards lets the
    // closest match to ptr overwrite any farther one.
    function automatic logic [RES_PE_NUM_WIDTH-1:0] rr_pick(
        input logic [PE_NUM-1:0]           req,
        input logic [RES_PE_NUM_WIDTH-1:0] ptr
    );
        logic [RES_PE_NUM_WIDTH-1:0] idx;
        rr_pick = ptr;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            idx = ptr + RES_PE_NUM_WIDTH'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO carrying an opaque payload, head exposed directly.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full unless popping in the same cycle.
module result_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         head_vld,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign head_dat = mem[rd_ptr];
    assign head_vld = (count != 2'd0);

    // Storage, pointers and occupancy; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/result_collector.sv
// Shared drain engine: round-robin over triggered PEs, streams each result SRAM out tagged.
// Latency: first word valid 2 cycles after the grant cycle; 1 word/cycle sustained.
// Backpressure: C_ready_in low holds the head word; reads stall on a 2-word credit.
module result_collector
    import result_pkg::*;
#(
    parameter int D_WIDTH      = RES_D_WIDTH,
    parameter int PE_NUM_WIDTH = RES_PE_NUM_WIDTH,
    parameter int ADDR_WIDTH   = RES_ADDR_WIDTH,
    localparam int NPE         = 1 << PE_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NPE-1:0]                   output_trigger_in,
    output logic [NPE-1:0]                   res_rd_en_out,
    output logic [NPE-1:0][ADDR_WIDTH-1:0]   res_rd_addr_out,
    input  logic [NPE-1:0][D_WIDTH-1:0]      res_rd_data_in,
    output logic [D_WIDTH-1:0]               C_data_out,
    output logic [PE_NUM_WIDTH-1:0]          C_pe_out,
    output logic [ADDR_WIDTH-1:0]            C_addr_out,
    output logic                             C_valid_out,
    input  logic                             C_ready_in,
    output logic                             busy_out,
    output logic                             done_out
);

    localparam int FIFO_W = D_WIDTH + $bits(result_tag_t);

    rc_state_t               state;
    logic [NPE-1:0]          pending;
    logic [PE_NUM_WIDTH-1:0] rr_ptr;
    logic [PE_NUM_WIDTH-1:0] cur_pe;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    inflight;
    result_tag_t             tag_d1;

    logic                    grant;
    logic [PE_NUM_WIDTH-1:0] grant_pe;
    logic [NPE-1:0]          grant_mask;
    logic                    credit_ok;
    logic                    issue;
    logic [PE_NUM_WIDTH-1:0] issue_pe;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [1:0]              fifo_count;
    logic [1:0]              occ_after;
    logic                    c_pop;
    logic [FIFO_W-1:0]       fifo_head;
    result_tag_t             head_tag;

    assign grant    = (state == IDLE) && (pending != '0);
    assign grant_pe = rr_pick(pending, rr_ptr);
    assign c_pop    = C_valid_out && C_ready_in;

    // Credit counts the slot freed by this cycle's pop so a ready sink sees 1 word/cycle.
    assign occ_after = fifo_count - {1'b0, c_pop};
    assign credit_ok = (occ_after + {1'b0, inflight}) < 2'd2;

    // The grant cycle also issues address 0, so consecutive drains leave no bubble.
    assign issue      = credit_ok && (grant || (state == DRAIN));
    assign issue_pe   = (state == IDLE) ? grant_pe : cur_pe;
    assign issue_addr = (state == IDLE) ? '0 : addr;

    // Read port fan-out: only the lane being read sees enable and a non-zero address.
    always_comb begin
        res_rd_en_out   = '0;
        res_rd_addr_out = '0;
        grant_mask      = '0;
        if (issue) begin
            res_rd_en_out[issue_pe]   = 1'b1;
            res_rd_addr_out[issue_pe] = issue_addr;
        end
        if (grant) grant_mask[grant_pe] = 1'b1;
    end

    // Trigger latch; a trigger coinciding with the grant survives the clear.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~grant_mask) | output_trigger_in;
    end

    // Drain FSM: pick a PE, walk its address space, hand the pointer past it on the last read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_pe <= '0;
            addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_pe <= grant_pe;
                        addr   <= issue ? ADDR_WIDTH'(1) : '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        if (&addr) begin
                            rr_ptr <= cur_pe + PE_NUM_WIDTH'(1);
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember which lane and address were read so the returning word is tagged correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_d1   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_d1.pe   <= issue_pe;
                tag_d1.addr <= issue_addr;
            end
        end
    end

    result_fifo2 #(.W(FIFO_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat ({res_rd_data_in[tag_d1.pe], tag_d1}),
        .pop      (c_pop),
        .head_dat (fifo_head),
        .head_vld (C_valid_out),
        .count    (fifo_count)
    );

    assign {C_data_out, head_tag} = fifo_head;
    assign C_pe_out   = head_tag.pe;
    assign C_addr_out = head_tag.addr;

    assign busy_out = (state == DRAIN) || (pending != '0) || (fifo_count != 2'd0) || inflight;
    assign done_out = c_pop && (fifo_count == 2'd1) && (state == IDLE) &&
                      (pending == '0) && !inflight;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;
    import result_pkg::*;

    logic                                      clk;
    logic                                      rst;
    logic [PE_NUM-1:0]                         trig;
    logic [PE_NUM-1:0]                         res_rd_en_out;
    logic [PE_NUM-1:0][RES_ADDR_WIDTH-1:0]     res_rd_addr_out;
    logic [PE_NUM-1:0][RES_D_WIDTH-1:0]        rd_data;
    logic [RES_D_WIDTH-1:0]                    C_data_out;
    logic [RES_PE_NUM_WIDTH-1:0]               C_pe_out;
    logic [RES_ADDR_WIDTH-1:0]                 C_addr_out;
    logic                                      C_valid_out;
    logic                                      C_ready_in;
    logic                                      busy_out;
    logic                                      done_out;

    result_collector dut (
        .clk               (clk),
        .rst               (rst),
        .output_trigger_in (trig),
        .res_rd_en_out     (res_rd_en_out),
        .res_rd_addr_out   (res_rd_addr_out),
        .res_rd_data_in    (rd_data),
        .C_data_out        (C_data_out),
        .C_pe_out          (C_pe_out),
        .C_addr_out        (C_addr_out),
        .C_valid_out       (C_valid_out),
        .C_ready_in        (C_ready_in),
        .busy_out          (busy_out),
        .done_out          (done_out)
    );

    typedef struct {
        logic [63:0] d;
        logic        pe;
        logic [4:0]  a;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pops = 0;
    int   done_cnt = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    bit   arm_first = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    int   ready_mode = 1;
    logic [63:0] prev_d;
    logic        prev_pe;
    logic [4:0]  prev_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference SRAM contents, distinct per PE and address.
    function automatic logic [63:0] gen(input int pe, input int a);
        logic [31:0] lo;
        lo = 32'(a) * 32'h0000_9E37 + 32'(pe) * 32'h0001_1111;
        return {16'hBEEF, 8'(pe), 8'(a), lo};
    endfunction

    // Result SRAM model with 1-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < PE_NUM; i++)
            if (res_rd_en_out[i]) rd_data[i] <= gen(i, int'(res_rd_addr_out[i]));
    end
    initial rd_data = '0;

    // Downstream ready driver: 0 = stalled, 1 = always ready, 2 = random 50%.
    initial begin
        C_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       C_ready_in = 1'b0;
                2:       C_ready_in = 1'($urandom_range(0, 1));
                default: C_ready_in = 1'b1;
            endcase
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_drain(input int pe);
        exp_t e;
        for (int a = 0; a < 32; a++) begin
            e.d  = gen(pe, a);
            e.pe = 1'(pe);
            e.a  = 5'(a);
            q.push_back(e);
        end
    endtask

    task automatic pulse(input logic [PE_NUM-1:0] m);
        @(posedge clk);
        #1 trig = m;
        @(posedge clk);
        #1 trig = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy_out) ok = 1;
        end
        check_eq({name, "_drain_finished"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_pops(input int target, input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (pops >= target) ok = 1;
        end
        check_eq({name, "_pops_reached"}, 64'(ok), 64'd1);
    endtask

    task automatic chk_zero(input string name);
        check_eq({name, "_valid"}, 64'(C_valid_out), 64'd0);
        check_eq({name, "_data"}, C_data_out, 64'd0);
        check_eq({name, "_pe"}, 64'(C_pe_out), 64'd0);
        check_eq({name, "_addr"}, 64'(C_addr_out), 64'd0);
        check_eq({name, "_rd_en"}, 64'(res_rd_en_out), 64'd0);
        check_eq({name, "_rd_addr"}, 64'(res_rd_addr_out), 64'd0);
        check_eq({name, "_busy"}, 64'(busy_out), 64'd0);
        check_eq({name, "_done"}, 64'(done_out), 64'd0);
    endtask

    // Monitor: read-port sanity, hold-while-stalled, scoreboard pop, done pulse.
    initial begin
        exp_t e;
        bit   exp_done;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_eq("rd_en_onehot", 64'($countones(res_rd_en_out) <= 1), 64'd1);
                for (int i = 0; i < PE_NUM; i++)
                    if (!res_rd_en_out[i])
                        check_eq("rd_addr_unselected", 64'(res_rd_addr_out[i]), 64'd0);
                if (prev_stall) begin
                    check_eq("hold_valid", 64'(C_valid_out), 64'd1);
                    check_eq("hold_data", C_data_out, prev_d);
                    check_eq("hold_pe", 64'(C_pe_out), 64'(prev_pe));
                    check_eq("hold_addr", 64'(C_addr_out), 64'(prev_a));
                end
                exp_done = 0;
                if (C_valid_out && C_ready_in) begin
                    if (q.size() == 0) begin
                        check_eq("unexpected_word", 64'(C_addr_out), 64'hFFFF);
                    end else begin
                        e = q.pop_front();
                        check_eq("word_data", C_data_out, e.d);
                        check_eq("word_pe", 64'(C_pe_out), 64'(e.pe));
                        check_eq("word_addr", 64'(C_addr_out), 64'(e.a));
                        exp_done = (q.size() == 0);
                    end
                    pops++;
                    last_pop_cyc = cyc;
                    if (arm_first) begin
                        first_pop_cyc = cyc;
                        arm_first = 0;
                    end
                end
                check_eq("done_pulse", 64'(done_out), 64'(exp_done));
                if (done_out) done_cnt++;
                prev_stall = C_valid_out && !C_ready_in;
                prev_d  = C_data_out;
                prev_pe = C_pe_out;
                prev_a  = C_addr_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tv, b, d0, n;
        rst = 1'b1;
        trig = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;

        // Single PE0 drain: latency from trigger, one done pulse.
        d0 = done_cnt;
        b = pops;
        @(posedge clk);
        #1 trig = 2'b01;
        push_drain(0);
        @(negedge clk);
        t0 = cyc;
        @(posedge clk);
        #1 trig = '0;
        tv = -100;
        for (int k = 0; k < 20 && tv < 0; k++) begin
            @(negedge clk);
            if (C_valid_out) tv = cyc;
        end
        check_eq("t1_first_valid_cycles_after_trigger", 64'(tv - t0), 64'd3);
        wait_idle(200, "t1");
        check_eq("t1_words", 64'(pops - b), 64'd32);
        check_eq("t1_done_count", 64'(done_cnt - d0), 64'd1);

        // PE1 re-triggered during its own drain: two full drains, one done.
        d0 = done_cnt;
        b = pops;
        pulse(2'b10);
        push_drain(1);
        wait_pops(b + 5, "t4");
        pulse(2'b10);
        push_drain(1);
        wait_idle(300, "t4");
        check_eq("t4_words", 64'(pops - b), 64'd64);
        check_eq("t4_done_count", 64'(done_cnt - d0), 64'd1);

        // Both PEs together with rr_ptr at 0: PE0 then PE1, no gap.
        b = pops;
        arm_first = 1;
        pulse(2'b11);
        push_drain(0);
        push_drain(1);
        wait_idle(300, "t2");
        check_eq("t2_words", 64'(pops - b), 64'd64);
        check_eq("t2_no_gap_span", 64'(last_pop_cyc - first_pop_cyc), 64'd63);

        // Random backpressure on a PE0 drain.
        ready_mode = 2;
        b = pops;
        pulse(2'b01);
        push_drain(0);
        wait_idle(800, "t3");
        ready_mode = 1;
        check_eq("t3_words", 64'(pops - b), 64'd32);

        // After PE0 the pointer sits at 1: PE1 must win a tie.
        pulse(2'b11);
        push_drain(1);
        push_drain(0);
        wait_idle(300, "rr");

        // Reset mid-drain with PE1 still pending.
        b = pops;
        pulse(2'b01);
        push_drain(0);
        repeat (3) @(posedge clk);
        pulse(2'b10);
        push_drain(1);
        wait_pops(b + 10, "t5");
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 0;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("t5_after_rst");
        prev_stall = 0;
        mon_en = 1;
        repeat (10) @(negedge clk);
        check_eq("t5_pending_cleared", 64'(busy_out), 64'd0);
        pulse(2'b01);
        push_drain(0);
        wait_idle(200, "t5_restart");

        // Stalled sink at drain start: exactly two reads, then resume from addr 0.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        pulse(2'b01);
        push_drain(0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_rd_en_out != '0) n++;
        end
        check_eq("t6_reads_while_stalled", 64'(n), 64'd2);
        ready_mode = 1;
        wait_idle(200, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream stage of the PE chain. Replaces the per-PE read-out triggers with one shared drain engine.
- Latches each PE's output_trigger pulse and arbitrates round-robin among PEs with pending results.
- Reads every word of the selected PE's result SRAM (1-cycle read latency) and emits the words as one C stream with valid/ready backpressure.
- Each output word is tagged with its PE index and local address; the block raises done when no work is outstanding.

Parameters:
- D_WIDTH, 64, result word width.
- PE_NUM_WIDTH, 1, log2 of PE count; PE_NUM = 1<<PE_NUM_WIDTH.
- ADDR_WIDTH, 5, PE result SRAM address width; words per PE = 1<<ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- output_trigger_in  in  PE_NUM  per-PE 1-cycle pulse: result SRAM ready to drain.
- res_rd_en_out  out  PE_NUM  per-PE SRAM read enable; at most one bit high.
- res_rd_addr_out  out  PE_NUM x ADDR_WIDTH  per-PE read address; non-selected lanes drive 0.
- res_rd_data_in  in  PE_NUM x D_WIDTH  per-PE read data, valid 1 cycle after rd_en.
- C_data_out  out  D_WIDTH  result word.
- C_pe_out  out  PE_NUM_WIDTH  source PE of C_data_out.
- C_addr_out  out  ADDR_WIDTH  source address of C_data_out.
- C_valid_out  out  1  output word valid.
- C_ready_in  in  1  downstream accepts the word when valid&ready.
- busy_out  out  1  high in DRAIN, or while pending or FIFO is non-empty.
- done_out  out  1  1-cycle pulse when the last word of a drain leaves and nothing is pending.

Behaviour:
- Reset: pending=0, state IDLE, rr_ptr=0, FIFO empty, inflight=0. All outputs drive 0.
- Pending register: pending[i] is set by output_trigger_in[i] and cleared when PE i is granted.
  - A trigger in the same cycle as the grant of that PE leaves pending set, so the PE is drained again later.
  - A trigger during a PE's own drain also re-sets pending.
- FSM states:
  - IDLE: if pending≠0, grant the first set bit at or after rr_ptr (wrapping), load cur_pe, set addr=0, go to DRAIN.
  - DRAIN: issue a read when (fifo_count + inflight) < 2. Drive res_rd_en_out[cur_pe]=1 with res_rd_addr_out[cur_pe]=addr, then addr++.
    - When the read at addr = all-ones issues, set rr_ptr = cur_pe+1 (mod PE_NUM) and go to IDLE.
    - A new grant can occur the next cycle, giving back-to-back drains with no gap.
- Read return: inflight is set for the cycle after each issue. res_rd_data_in[cur_pe_d1] is pushed into the 2-entry output FIFO together with the {pe, addr} tag captured at issue.
- Output FIFO:
  - Depth 2. Head drives C_*_out; pop on C_valid_out & C_ready_in.
  - Simultaneous push and pop is allowed at any occupancy.
  - The credit rule means the FIFO never overflows.
- Throughput: with C_ready_in held high, 1 word/cycle sustained. The first word of a drain appears 2 cycles after the grant cycle (issue +1, registered FIFO +1).
- Backpressure:
  - C_valid_out, C_data_out, C_pe_out and C_addr_out stay stable while valid & !ready.
  - Reads stall with no lost or duplicated words.
- done_out pulses when the FIFO pops its last entry while state=IDLE, pending=0 and inflight=0.
- rst mid-drain: everything aborts to the reset state immediately. Pending triggers are lost; re-triggering is upstream's responsibility.
- Address counter is ADDR_WIDTH bits. The terminal read is detected on all-ones, before the counter wraps.

Decomposition:
- Package result_pkg holds:
  - localparam PE_NUM;
  - typedef result_tag_t {pe, addr};
  - typedef enum {IDLE, DRAIN} rc_state_t.
- Sub-module: result_fifo2, a 2-entry synchronous FIFO with data+tag, push/pop, and count output. It is reused by other stream stages.

Test Plan:
- Single trigger PE0, ready=1 → 32 words, C_addr 0..31, C_pe=0, first valid 2 cycles after grant, done pulse after word 31.
- Triggers PE0 and PE1 in the same cycle, rr_ptr=0 → PE0's 32 words then PE1's 32, no idle cycle between drains, rr_ptr ends at 0.
- Random C_ready_in (50%) during one PE0 drain → all 32 words in order, held stable while stalled, FIFO count never exceeds 2.
- PE1 re-triggers during its own drain → after 32 words, a second full PE1 drain of 32 words; a single done pulse after the second drain.
- Assert rst at word 10 of a drain → next cycle all outputs 0, pending cleared; a subsequent trigger restarts from addr 0.
- ready=0 for 20 cycles at the start of a drain → exactly 2 reads issued, then the read stalls; on ready=1 the stream resumes at addr 0 with no loss.
